// File: rtl/stream_demultiplexor.sv
// stream_demultiplexor
// Routes one valid/ready input stream into two output lanes (A and B).
// Each lane has a one-entry output register. The select bit travels with
// the data and names the destination lane.
// Optional feature: define DEMUX_COUNT_EN to add the per-lane delivered-word
// counters and their ports a_count / b_count.
module stream_demultiplexor #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             select,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
`endif
);

    logic a_load;
    logic b_load;
    logic a_drain;
    logic b_drain;
    logic a_space;
    logic b_space;

    // A lane has room this cycle when it is empty or its word is leaving
    assign a_space  = ~a_valid | a_ready;
    assign b_space  = ~b_valid | b_ready;

    // Accept the input only if the lane it is addressed to has room
    assign in_ready = ~rst & (select ? b_space : a_space);

    assign a_load   = in_valid & in_ready & ~select;
    assign b_load   = in_valid & in_ready &  select;
    assign a_drain  = a_valid & a_ready;
    assign b_drain  = b_valid & b_ready;

    // Lane A register: a reload wins over a drain, so there is no bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_data  <= '0;
        end else if (a_load) begin
            a_valid <= 1'b1;
            a_data  <= in_data;
        end else if (a_drain) begin
            a_valid <= 1'b0;
        end
    end

    // Lane B register: same behaviour as lane A
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid <= 1'b0;
            b_data  <= '0;
        end else if (b_load) begin
            b_valid <= 1'b1;
            b_data  <= in_data;
        end else if (b_drain) begin
            b_valid <= 1'b0;
        end
    end

`ifdef DEMUX_COUNT_EN
    // Delivered-word counters; they wrap freely and ignore drains under reset
    always_ff @(posedge clk) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_drain) begin
                a_count <= a_count + CNT_W'(1);
            end
            if (b_drain) begin
                b_count <= b_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/stream_demultiplexor.md
STREAM_DEMULTIPLEXOR -- requirements
Module: stream_demultiplexor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64, the data width in bits of the input and of each output lane.
REQ-002 The module SHALL have parameter CNT_W, default 16, the width in bits of each lane transfer counter.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  the input word is valid.
REQ-006 Port in_ready  output  1  the block accepts the input word this cycle.
REQ-007 Port in_data  input  WIDTH  input word.
REQ-008 Port select  input  1  destination lane: 0 = lane A, 1 = lane B; sampled with in_data.
REQ-009 Port a_valid / b_valid  output  1  the lane register holds a word.
REQ-010 Port a_ready / b_ready  input  1  the lane consumer accepts the word.
REQ-011 Port a_data / b_data  output  WIDTH  the lane register contents.
REQ-012 Port a_count / b_count  output  CNT_W  words delivered per lane; present only under DEMUX_COUNT_EN.

Function
REQ-013 Each lane SHALL hold a one-entry output register with a valid flag.
REQ-014 in_ready SHALL be combinational: (~a_valid | a_ready) when select=0, and (~b_valid | b_ready) when select=1.
REQ-015 An input transfer (in_valid & in_ready) SHALL load in_data into the selected lane register and set its valid bit on the next edge; latency is one cycle.
REQ-016 The unselected lane SHALL never be loaded, and its valid/data SHALL be unaffected by the input transfer.
REQ-017 An output transfer (x_valid & x_ready) SHALL clear x_valid on the next edge unless the same lane is reloaded in that cycle.
REQ-018 On a simultaneous drain and reload of the same lane, x_valid SHALL stay 1 and x_data SHALL take the new word, with no bubble.
REQ-019 While x_valid=1 and x_ready=0, x_data SHALL be held stable.
REQ-020 Changes on select or in_data while in_valid=0 SHALL have no effect on state.
REQ-021 Both lanes MAY drain in the same cycle, independently of the input.
REQ-022 A stalled lane SHALL NOT block traffic directed to the other lane.
REQ-023 Words SHALL reach each lane in input order, with no loss or duplication.
REQ-024 Each counter SHALL increment by 1 on every output transfer of its lane.
REQ-025 Each counter SHALL wrap modulo 2^CNT_W (16'hFFFF -> 16'h0000) with no saturation flag.

Reset
REQ-026 On rst=1 at a clock edge, a_valid and b_valid SHALL be 0, a_data and b_data SHALL be 0, and the counters SHALL be 0.
REQ-027 While rst=1, in_ready SHALL be 0.
REQ-028 A reset asserted mid-operation SHALL discard held words, and no output transfer SHALL be counted in that cycle.

Configuration
REQ-029 With macro DEMUX_COUNT_EN defined, the design SHALL include the ports a_count and b_count and the counter logic described in REQ-024 and REQ-025.
REQ-030 Without DEMUX_COUNT_EN, those ports and that logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then in_data=64'h123456789ABCDEF0 with select=0, and a_ready=0 -> the next cycle a_valid=1, a_data=64'h123456789ABCDEF0, and b_valid=0.
REQ-032 With lane A full and a_ready=0, drive select=0 and in_valid=1 -> in_ready=0; then switch to select=1 with in_data=64'hFFFFFFFFFFFFFFFF -> in_ready=1, and b_data=64'hFFFFFFFFFFFFFFFF one cycle later.
REQ-033 Hold a_ready=1 and stream 64'h1, 64'h2, 64'h3 back-to-back on select=0 -> a_data shows 1, 2, 3 on consecutive cycles and a_valid stays 1 throughout.
REQ-034 Alternate select 0,1,0,1 with both readies high -> words appear alternately on lanes A and B in order, and with DEMUX_COUNT_EN a_count=2 and b_count=2.
REQ-035 Assert rst for one cycle while both lanes are full -> both valids are 0 and both counts are 0 the next cycle, and in_ready=0 during the reset cycle.
REQ-036 With DEMUX_COUNT_EN, preload a_count=16'hFFFF via 65535 transfers, then perform one more transfer -> a_count=16'h0000.
